// File: rtl/ex_sequencer.sv
// rtl/ex_sequencer.sv - EX-stage control sequencer: decode, MDU launch/timeout, valid/ready handshakes
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               kills the in-flight instruction (synchronous)
//   in_valid/in_ready   instruction handshake from ID
//   opcode/func3/func7  decoded instruction fields
//   mdu_done            single-cycle MDU completion pulse
//   aluctl/mulctl       registered ALU and MDU operation selects
//   ifuresctl           registered result mux select (0 = ALU, 1 = MDU)
//   mdu_start/abort     one-cycle MDU launch / cancel pulses
//   out_valid/out_ready result handshake to MEM
//   illegal/timeout     result qualifiers, meaningful with out_valid

module ex_sequencer #(
    parameter int IFURES_N    = 2,
    parameter bit ENABLE_M    = 1'b1,
    parameter int MDU_TIMEOUT = 64,
    parameter int TMO_W       = $clog2(MDU_TIMEOUT + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [6:0]                  opcode,
    input  logic [2:0]                  func3,
    input  logic [6:0]                  func7,
    input  logic                        mdu_done,
    output logic [3:0]                  aluctl,
    output logic [2:0]                  mulctl,
    output logic                        mdu_start,
    output logic                        mdu_abort,
    output logic [$clog2(IFURES_N)-1:0] ifuresctl,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        illegal,
    output logic                        timeout
);

    localparam int IFW = $clog2(IFURES_N);
    localparam logic [IFW-1:0] RES_ALU = '0;
    localparam logic [IFW-1:0] RES_MDU = IFW'(1);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULD = 7'b0000001;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] busy_cnt;
    logic             run_q;
    logic             accept;
    logic             produce_alu, launch, finish_ok, finish_tmo;
    logic [3:0]       dec_alu;
    logic             dec_mdu, dec_ill;

    // Instruction decode
    always_comb begin
        dec_alu = ALU_ADD;
        dec_mdu = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (func7 == F7_MULD) begin
                    if (ENABLE_M) dec_mdu = 1'b1;
                    else          dec_ill = 1'b1;
                end else if (func7 == F7_BASE || func7 == F7_ALT) begin
                    case (func3)
                        3'b000: dec_alu = func7[5] ? ALU_SUB : ALU_ADD;
                        3'b001: dec_alu = ALU_SLL;
                        3'b010: dec_alu = ALU_SLT;
                        3'b011: dec_alu = ALU_SLTU;
                        3'b100: dec_alu = ALU_XOR;
                        3'b101: dec_alu = func7[5] ? ALU_SRA : ALU_SRL;
                        3'b110: dec_alu = ALU_OR;
                        default: dec_alu = ALU_AND;
                    endcase
                    // Only add/sub and srl/sra have an alternate encoding
                    if (func7[5] && func3 != 3'b000 && func3 != 3'b101)
                        dec_ill = 1'b1;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                // func7 is immediate data except for the shift encodings
                case (func3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b001: begin
                        dec_alu = ALU_SLL;
                        if (func7 != F7_BASE) dec_ill = 1'b1;
                    end
                    3'b010: dec_alu = ALU_SLT;
                    3'b011: dec_alu = ALU_SLTU;
                    3'b100: dec_alu = ALU_XOR;
                    3'b101: begin
                        if (func7 == F7_BASE)     dec_alu = ALU_SRL;
                        else if (func7 == F7_ALT) dec_alu = ALU_SRA;
                        else                      dec_ill = 1'b1;
                    end
                    3'b110: dec_alu = ALU_OR;
                    default: dec_alu = ALU_AND;
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                dec_alu = ALU_ADD;
            end
            OPC_BRANCH: begin
                case (func3)
                    3'b000, 3'b001: dec_alu = ALU_SUB;
                    3'b100, 3'b101: dec_alu = ALU_SLT;
                    3'b110, 3'b111: dec_alu = ALU_SLTU;
                    default:        dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal instructions always report the AND encoding
        if (dec_ill) dec_alu = ALU_AND;
    end

    // run_q keeps in_ready low until the first clock after reset release
    assign in_ready = run_q && (state_q == IDLE) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        produce_alu = 1'b0;
        launch      = 1'b0;
        finish_ok   = 1'b0;
        finish_tmo  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_mdu) begin
                        launch  = 1'b1;
                        state_d = BUSY;
                    end else begin
                        produce_alu = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (mdu_done) begin
                    // done on the final allowed cycle still beats the timeout
                    finish_ok = 1'b1;
                    state_d   = IDLE;
                end else if (busy_cnt + TMO_W'(1) == TMO_W'(MDU_TIMEOUT)) begin
                    finish_tmo = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= 1'b0;
            busy_cnt  <= '0;
            aluctl    <= ALU_ADD;
            mulctl    <= 3'b000;
            ifuresctl <= RES_ALU;
            mdu_start <= 1'b0;
            mdu_abort <= 1'b0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            mdu_start <= launch;
            mdu_abort <= finish_tmo || (flush && state_q == BUSY);

            if (state_q == BUSY && !flush) busy_cnt <= busy_cnt + TMO_W'(1);
            else                           busy_cnt <= '0;

            if (accept) begin
                aluctl    <= dec_alu;
                mulctl    <= dec_mdu ? func3 : 3'b000;
                ifuresctl <= dec_mdu ? RES_MDU : RES_ALU;
            end

            if (flush) begin
                out_valid <= 1'b0;
                illegal   <= 1'b0;
                timeout   <= 1'b0;
            end else if (produce_alu) begin
                out_valid <= 1'b1;
                illegal   <= dec_ill;
                timeout   <= 1'b0;
            end else if (finish_ok || finish_tmo) begin
                out_valid <= 1'b1;
                illegal   <= 1'b0;
                timeout   <= finish_tmo;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                illegal   <= 1'b0;
                timeout   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_sequencer.sv
// tb/tb_ex_sequencer.sv - randomized self-checking bench for ex_sequencer (M enabled and disabled)

module tb_ex_sequencer;

    localparam int TMO = 8;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic       mdu_done = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_0, mdu_start_0, mdu_abort_0, out_valid_0, illegal_0, timeout_0, ifuresctl_0;
    logic [3:0] aluctl_0;
    logic [2:0] mulctl_0;
    logic       in_ready_1, mdu_start_1, mdu_abort_1, out_valid_1, illegal_1, timeout_1, ifuresctl_1;
    logic [3:0] aluctl_1;
    logic [2:0] mulctl_1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ex_sequencer #(.IFURES_N(2), .ENABLE_M(1'b1), .MDU_TIMEOUT(TMO)) u_m (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_0),
        .opcode(opcode), .func3(func3), .func7(func7), .mdu_done(mdu_done),
        .aluctl(aluctl_0), .mulctl(mulctl_0), .mdu_start(mdu_start_0), .mdu_abort(mdu_abort_0),
        .ifuresctl(ifuresctl_0), .out_valid(out_valid_0), .out_ready(out_ready),
        .illegal(illegal_0), .timeout(timeout_0)
    );

    ex_sequencer #(.IFURES_N(2), .ENABLE_M(1'b0), .MDU_TIMEOUT(TMO)) u_nm (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_1),
        .opcode(opcode), .func3(func3), .func7(func7), .mdu_done(mdu_done),
        .aluctl(aluctl_1), .mulctl(mulctl_1), .mdu_start(mdu_start_1), .mdu_abort(mdu_abort_1),
        .ifuresctl(ifuresctl_1), .out_valid(out_valid_1), .out_ready(out_ready),
        .illegal(illegal_1), .timeout(timeout_1)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [3:0] alu;
        logic       mdu;
        logic       ill;
    } dec_t;

    // Table-driven decode: base op per func3 (add sll slt sltu xor srl or and);
    // the alternate func7 encoding selects the next code (add->sub, srl->sra).
    function automatic dec_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input bit en_m);
        logic [3:0] base [8];
        dec_t d;
        base = '{4'd0, 4'd5, 4'd8, 4'd9, 4'd2, 4'd6, 4'd3, 4'd4};
        d = '{alu: 4'd0, mdu: 1'b0, ill: 1'b0};
        if (op == OP) begin
            if (f7 == 7'h01) begin
                if (en_m) d.mdu = 1'b1; else d.ill = 1'b1;
            end else if (f7 == 7'h00) d.alu = base[f3];
            else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) d.alu = base[f3] + 4'd1;
            else d.ill = 1'b1;
        end else if (op == OP_IMM) begin
            if (f3 == 3'd0) d.alu = 4'd0;
            else if (f3 == 3'd1) begin
                if (f7 == 7'h00) d.alu = base[1]; else d.ill = 1'b1;
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00) d.alu = base[5];
                else if (f7 == 7'h20) d.alu = base[5] + 4'd1;
                else d.ill = 1'b1;
            end else d.alu = base[f3];
        end else if (op == BRANCH) begin
            if (f3[2:1] == 2'b00) d.alu = 4'd1;
            else if (f3[2:1] == 2'b10) d.alu = 4'd8;
            else if (f3[2:1] == 2'b11) d.alu = 4'd9;
            else d.ill = 1'b1;
        end else if (op == LOAD || op == 7'b0100011 || op == 7'b0110111 || op == 7'b0010111 ||
                     op == 7'b1101111 || op == 7'b1100111) begin
            d.alu = 4'd0;
        end else d.ill = 1'b1;
        if (d.ill) d.alu = 4'd4;
        return d;
    endfunction

    bit         m_run [2];
    bit         m_busy [2];
    int         m_age [2];     // busy cycles elapsed for the pending MDU op
    logic [3:0] m_alu [2];
    logic [2:0] m_mul [2];
    logic       m_ifr [2], m_ov [2], m_ill [2], m_tmo [2], m_start [2], m_abort [2];

    function automatic logic m_ready(input int i);
        return m_run[i] && !m_busy[i] && (!m_ov[i] || out_ready) && !flush;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_busy[i] = 0; m_age[i] = 0;
            m_alu[i] = '0; m_mul[i] = '0; m_ifr[i] = 0;
            m_ov[i] = 0; m_ill[i] = 0; m_tmo[i] = 0; m_start[i] = 0; m_abort[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic rdy;
            dec_t d;
            rdy = m_ready(i);
            m_start[i] = 0;
            m_abort[i] = 0;
            if (flush) begin
                m_abort[i] = m_busy[i];
                m_busy[i] = 0;
                m_ov[i] = 0; m_ill[i] = 0; m_tmo[i] = 0;
            end else begin
                if (m_ov[i] && out_ready) begin
                    m_ov[i] = 0; m_ill[i] = 0; m_tmo[i] = 0;
                end
                if (m_busy[i]) begin
                    m_age[i]++;
                    if (mdu_done) begin
                        m_busy[i] = 0; m_ov[i] = 1; m_ill[i] = 0; m_tmo[i] = 0;
                    end else if (m_age[i] == TMO) begin
                        m_busy[i] = 0; m_ov[i] = 1; m_ill[i] = 0; m_tmo[i] = 1; m_abort[i] = 1;
                    end
                end else if (in_valid && rdy) begin
                    d = ref_decode(opcode, func3, func7, i == 0);
                    m_alu[i] = d.alu;
                    m_mul[i] = d.mdu ? func3 : 3'd0;
                    m_ifr[i] = d.mdu;
                    if (d.mdu) begin
                        m_busy[i] = 1; m_age[i] = 0; m_start[i] = 1;
                    end else begin
                        m_ov[i] = 1; m_ill[i] = d.ill; m_tmo[i] = 0;
                    end
                end
            end
            m_run[i] = 1;
        end
    endtask

    // ---------------- comparison ----------------
    task automatic cmp(input string nm, input int i, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    task automatic check_inst(input int i, input logic ir, input logic ov, input logic [3:0] alu,
                              input logic [2:0] mul, input logic ifr, input logic ill,
                              input logic tmo, input logic st, input logic ab);
        cmp("in_ready", i, {3'd0, ir}, {3'd0, m_ready(i)});
        cmp("out_valid", i, {3'd0, ov}, {3'd0, m_ov[i]});
        cmp("aluctl", i, alu, m_alu[i]);
        cmp("mulctl", i, {1'b0, mul}, {1'b0, m_mul[i]});
        cmp("ifuresctl", i, {3'd0, ifr}, {3'd0, m_ifr[i]});
        cmp("illegal", i, {3'd0, ill}, {3'd0, m_ill[i]});
        cmp("timeout", i, {3'd0, tmo}, {3'd0, m_tmo[i]});
        cmp("mdu_start", i, {3'd0, st}, {3'd0, m_start[i]});
        cmp("mdu_abort", i, {3'd0, ab}, {3'd0, m_abort[i]});
    endtask

    // One clock: drive at the falling edge, compare 1 ns later, advance the model.
    task automatic cycle(input bit rst, input bit v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input bit ordy, input bit done, input bit fl);
        @(negedge clk);
        rst_n = rst; in_valid = v; opcode = op; func3 = f3; func7 = f7;
        out_ready = ordy; mdu_done = done; flush = fl;
        #1;
        if (!rst_n) model_reset();
        check_inst(0, in_ready_0, out_valid_0, aluctl_0, mulctl_0, ifuresctl_0, illegal_0, timeout_0, mdu_start_0, mdu_abort_0);
        check_inst(1, in_ready_1, out_valid_1, aluctl_1, mulctl_1, ifuresctl_1, illegal_1, timeout_1, mdu_start_1, mdu_abort_1);
        if (rst_n) model_step();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1, 0, 7'd0, 3'd0, 7'd0, 1, 0, 0);
    endtask

    task automatic rand_cycle();
        logic [6:0] op, f7;
        logic [2:0] f3;
        case ($urandom_range(0, 9))
            0, 1, 2, 9: op = OP;
            3, 4:       op = OP_IMM;
            5:          op = BRANCH;
            6:          op = LOAD;
            7: begin
                case ($urandom_range(0, 4))
                    0: op = 7'b0100011;
                    1: op = 7'b0110111;
                    2: op = 7'b0010111;
                    3: op = 7'b1101111;
                    default: op = 7'b1100111;
                endcase
            end
            default: op = 7'($urandom);
        endcase
        f3 = 3'($urandom);
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
        endcase
        cycle($urandom_range(0, 499) != 0, $urandom_range(0, 9) < 7, op, f3, f7,
              $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    endtask

    initial begin
        int seen;
        model_reset();

        // model pinned against hand-decoded encodings
        cmp("ref_sub", 0, ref_decode(OP, 3'd0, 7'h20, 1).alu, 4'b0001);
        cmp("ref_sra_imm", 0, ref_decode(OP_IMM, 3'd5, 7'h20, 1).alu, 4'b0111);
        cmp("ref_bltu", 0, ref_decode(BRANCH, 3'd6, 7'h00, 1).alu, 4'b1001);
        cmp("ref_divu_nom", 1, {3'd0, ref_decode(OP, 3'd5, 7'h01, 0).ill}, 4'd1);
        cmp("ref_bad_opc", 0, ref_decode(7'h7f, 3'd0, 7'h00, 1).alu, 4'b0100);

        // reset
        cycle(0, 1, OP, 3'd0, 7'h00, 1, 0, 0);
        cmp("rst_in_ready", 0, {3'd0, in_ready_0}, 4'd0);
        cycle(1, 0, 7'd0, 3'd0, 7'd0, 1, 0, 0);
        cmp("rel_in_ready", 0, {3'd0, in_ready_0}, 4'd0);
        idle(1);
        cmp("run_in_ready", 0, {3'd0, in_ready_0}, 4'd1);

        // add then sub back to back
        cycle(1, 1, OP, 3'd0, 7'h00, 1, 0, 0);
        cycle(1, 1, OP, 3'd0, 7'h20, 1, 0, 0);
        cmp("add_alu", 0, aluctl_0, 4'b0000);
        cmp("add_valid", 0, {3'd0, out_valid_0}, 4'd1);
        idle(1);
        cmp("sub_alu", 0, aluctl_0, 4'b0001);
        cmp("sub_valid", 0, {3'd0, out_valid_0}, 4'd1);
        cmp("sub_ifr", 0, {3'd0, ifuresctl_0}, 4'd0);
        idle(1);

        // MUL with done five cycles after start
        cycle(1, 1, OP, 3'd0, 7'h01, 1, 0, 0);
        cycle(1, 1, OP, 3'd0, 7'h00, 1, 0, 0);
        cmp("mul_start", 0, {3'd0, mdu_start_0}, 4'd1);
        cmp("mul_busy_rdy", 0, {3'd0, in_ready_0}, 4'd0);
        for (int k = 0; k < 4; k++) cycle(1, 1, OP, 3'd0, 7'h00, 1, 0, 0);
        cycle(1, 0, 7'd0, 3'd0, 7'd0, 1, 1, 0);
        idle(1);
        cmp("mul_valid", 0, {3'd0, out_valid_0}, 4'd1);
        cmp("mul_ifr", 0, {3'd0, ifuresctl_0}, 4'd1);
        cmp("mul_mulctl", 0, {1'b0, mulctl_0}, 4'd0);
        idle(2);

        // timeout: abort appears after the start cycle plus TMO busy cycles
        cycle(1, 1, OP, 3'd3, 7'h01, 1, 0, 0);
        seen = 0;
        for (int k = 1; k <= 3 * TMO; k++) begin
            idle(1);
            if (mdu_abort_0 === 1'b1) begin
                seen = k;
                break;
            end
        end
        cmp("tmo_cycles", 0, 4'(seen), 4'(TMO + 1));
        cmp("tmo_flag", 0, {3'd0, timeout_0}, 4'd1);
        cmp("tmo_valid", 0, {3'd0, out_valid_0}, 4'd1);
        cycle(1, 1, OP, 3'd4, 7'h00, 1, 0, 0);
        idle(1);
        cmp("post_tmo_xor", 0, aluctl_0, 4'b0010);

        // back-pressure with in_valid held
        cycle(1, 1, OP, 3'd0, 7'h00, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, OP, 3'd6, 7'h00, 0, 0, 0);
            cmp("bp_rdy", 0, {3'd0, in_ready_0}, 4'd0);
            cmp("bp_alu", 0, aluctl_0, 4'b0000);
        end
        cycle(1, 1, OP, 3'd6, 7'h00, 1, 0, 0);
        cmp("bp_accept", 0, {3'd0, in_ready_0}, 4'd1);
        idle(1);
        cmp("bp_or", 0, aluctl_0, 4'b0011);
        idle(1);

        // flush in BUSY with a coincident done
        cycle(1, 1, OP, 3'd1, 7'h01, 1, 0, 0);
        idle(2);
        cycle(1, 0, 7'd0, 3'd0, 7'd0, 1, 1, 1);
        idle(1);
        cmp("fl_abort", 0, {3'd0, mdu_abort_0}, 4'd1);
        cmp("fl_valid", 0, {3'd0, out_valid_0}, 4'd0);
        cmp("fl_idle", 0, {3'd0, in_ready_0}, 4'd1);
        idle(1);

        // illegal opcode, then DIVU on the M-disabled instance
        cycle(1, 1, 7'h7f, 3'd0, 7'h00, 1, 0, 0);
        cycle(1, 1, OP, 3'd5, 7'h01, 1, 0, 0);
        cmp("bad_ill", 0, {3'd0, illegal_0}, 4'd1);
        cmp("bad_alu", 0, aluctl_0, 4'b0100);
        idle(1);
        cmp("divu_ill", 1, {3'd0, illegal_1}, 4'd1);
        cmp("divu_valid", 1, {3'd0, out_valid_1}, 4'd1);
        cmp("divu_nostart", 1, {3'd0, mdu_start_1}, 4'd0);
        cycle(1, 0, 7'd0, 3'd0, 7'd0, 1, 0, 1);
        idle(1);

        // asynchronous reset mid-BUSY: no abort pulse
        cycle(1, 1, OP, 3'd4, 7'h01, 1, 0, 0);
        idle(2);
        cycle(0, 0, 7'd0, 3'd0, 7'd0, 1, 0, 0);
        cmp("arst_abort", 0, {3'd0, mdu_abort_0}, 4'd0);
        cmp("arst_start", 0, {3'd0, mdu_start_0}, 4'd0);
        idle(2);

        for (int n = 0; n < 4000; n++) rand_cycle();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
